// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: column-scanned keypad with per-frame debounce, multi-key rejection
// and a show-ahead event FIFO (press / repeat / release).
module keypad_scan_fifo #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int DEBOUNCE   = 3,
   parameter int REPEAT     = 0,
   parameter int FIFO_DEPTH = 8,
   parameter int CODE_W     = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   fila,
   output logic [COLS-1:0]   col,
   output logic              key_down,
   output logic [CODE_W-1:0] key_code,
   output logic              evt_valid,
   output logic [CODE_W-1:0] evt_code,
   output logic [1:0]        evt_type,
   input  logic              evt_rd,
   output logic              overflow,
   input  logic              clr_overflow
);
   localparam int CW  = $clog2(COLS);
   localparam int DW  = $clog2(SCAN_DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int DBW = $clog2(DEBOUNCE+1)+1;
   localparam int RW  = $clog2(REPEAT+1)+1;
   typedef enum logic [1:0] {IDLE, CONFIRM, HELD, REL} state_t;
   state_t st;
   logic [ROWS-1:0] fila_m, fila_s;
   logic [DW-1:0] div;
   logic [CW-1:0] cidx;
   logic [1:0] n_acc, n_tot;
   logic [CODE_W-1:0] c_acc, c_tot, cand, pcode;
   logic h_acc, h_tot, sample, frame_end, single, push, pop, wr, full;
   logic [DBW-1:0] cnt, rcnt;
   logic [RW-1:0] rep;
   logic [1:0] ptype;
   logic [CODE_W+1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] used;
   assign col       = ~(COLS'(1) << cidx);
   assign sample    = div == DW'(SCAN_DIV-1);
   assign frame_end = sample && cidx == CW'(COLS-1);
   assign single    = n_tot == 2'd1;
   assign key_code  = cand;
   // Fold the current column into the frame summary; count saturates at 2 (multi).
   always_comb begin
      n_tot = n_acc;
      c_tot = c_acc;
      h_tot = h_acc;
      for (int r = 0; r < ROWS; r++)
         if (!fila_s[r]) begin
            n_tot = (n_tot == 2'd0) ? 2'd1 : 2'd2;
            c_tot = CODE_W'(r*COLS + int'(cidx));
            h_tot = h_tot | (c_tot == cand);
         end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fila_m <= '1;
         fila_s <= '1;
         div    <= '0;
         cidx   <= '0;
         n_acc  <= '0;
         c_acc  <= '0;
         h_acc  <= 1'b0;
      end else begin
         fila_m <= fila;
         fila_s <= fila_m;
         div    <= sample ? '0 : div + DW'(1);
         if (sample) begin
            cidx  <= frame_end ? '0 : cidx + CW'(1);
            n_acc <= frame_end ? '0 : n_tot;
            c_acc <= frame_end ? '0 : c_tot;
            h_acc <= frame_end ? 1'b0 : h_tot;
         end
      end
   always_comb begin
      push  = 1'b0;
      ptype = 2'b00;
      pcode = cand;
      if (frame_end)
         case (st)
            IDLE: begin
               push  = single && DEBOUNCE == 1;
               pcode = c_tot;
            end
            CONFIRM: push = single && c_tot == cand && cnt == DBW'(DEBOUNCE-1);
            HELD: begin
               push  = h_tot ? (REPEAT > 0 && rep == RW'(REPEAT-1)) : DEBOUNCE == 1;
               ptype = h_tot ? 2'b01 : 2'b10;
            end
            default: begin
               push  = !h_tot && rcnt == DBW'(DEBOUNCE-1);
               ptype = 2'b10;
            end
         endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st       <= IDLE;
         cand     <= '0;
         cnt      <= '0;
         rcnt     <= '0;
         rep      <= '0;
         key_down <= 1'b0;
      end else if (frame_end)
         case (st)
            IDLE:
               if (single) begin
                  cand     <= c_tot;
                  cnt      <= DBW'(1);
                  rep      <= '0;
                  st       <= DEBOUNCE == 1 ? HELD : CONFIRM;
                  key_down <= DEBOUNCE == 1;
               end
            CONFIRM:
               if (single && c_tot == cand) begin
                  cnt <= cnt + DBW'(1);
                  if (push) begin
                     st       <= HELD;
                     key_down <= 1'b1;
                     rep      <= '0;
                  end
               end else st <= IDLE;
            HELD:
               if (h_tot) rep <= push ? '0 : rep + RW'(REPEAT > 0);
               else begin
                  rcnt     <= DBW'(1);
                  st       <= DEBOUNCE == 1 ? IDLE : REL;
                  key_down <= DEBOUNCE != 1;
               end
            default:
               if (h_tot) st <= HELD;
               else begin
                  rcnt <= rcnt + DBW'(1);
                  if (push) begin
                     st       <= IDLE;
                     key_down <= 1'b0;
                  end
               end
         endcase
   assign full      = used[AW];
   assign evt_valid = used != '0;
   assign pop       = evt_rd && evt_valid;
   assign wr        = push && (!full || pop);
   assign {evt_type, evt_code} = evt_valid ? mem[rp] : '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         used     <= '0;
         overflow <= 1'b0;
      end else begin
         wp       <= wp + AW'(wr);
         rp       <= rp + AW'(pop);
         used     <= used + (AW+1)'(wr) - (AW+1)'(pop);
         overflow <= (push && !wr) || (overflow && !clr_overflow);
      end
   always_ff @(posedge clk)
      if (wr) mem[wp] <= {ptype, pcode};
endmodule
